add_seq_nbit: RTL

ADD_SEQ_NBIT -- requirements
Module: add_seq_nbit

---
 rtl/add_pkg.sv | 18 +
 rtl/add_chunk.sv | 28 ++
 rtl/add_seq_nbit.sv | 118 +++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// ============================================================================
// add_pkg : shared constants for the sequential chunked adder
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package add_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CHUNK_DEF = 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/add_chunk.sv
// ============================================================================
// add_chunk : combinational CHUNK-bit adder with carry-out and carry-into-MSB
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module add_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   input  logic             i_cin,
   output logic [CHUNK-1:0] o_sum,
   output logic             o_cout,
   output logic             o_cmsb
);

   logic [CHUNK:0] w_full;

   assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
   assign o_sum  = w_full[CHUNK-1:0];
   assign o_cout = w_full[CHUNK];
   // Carry into the top bit is recovered from the sum bit and its two addends
   assign o_cmsb = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ w_full[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/add_seq_nbit.sv
// ============================================================================
// add_seq_nbit : WIDTH-bit add/subtract computed CHUNK bits per clock
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module add_seq_nbit
   import add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             C_IN,
   input  logic             SUB,
   output logic [WIDTH-1:0] Z,
   output logic             C_OUT,
   output logic             OVF,
   output logic             ZERO,
   output logic             OUT_VALID,
   input  logic             OUT_READY
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_z;
   logic             r_carry;
   logic [KW-1:0]    r_k;
   logic             r_cout;
   logic             r_ovf;

   logic [CHUNK-1:0]       w_sum;
   logic                   w_cout;
   logic                   w_cmsb;
   logic                   w_last;
   logic [WIDTH+CHUNK-1:0] w_zcat;

   add_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .i_a    (r_x[CHUNK-1:0]),
      .i_b    (r_y[CHUNK-1:0]),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout),
      .o_cmsb (w_cmsb)
   );

   assign w_last = (r_k == KW'(NCHUNK - 1));
   // Operands shift down and the result shifts in from the top, so the
   // active chunk is always bits [CHUNK-1:0] and Z lands aligned after NCHUNK steps.
   assign w_zcat = {w_sum, r_z};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_carry <= 1'b0;
         r_k     <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (IN_VALID) begin
                  r_x     <= X;
                  // Subtraction is X + ~Y + 1; inversion is folded in at capture
                  r_y     <= SUB ? ~Y : Y;
                  r_carry <= SUB ? 1'b1 : C_IN;
                  r_k     <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_x     <= r_x >> CHUNK;
               r_y     <= r_y >> CHUNK;
               r_z     <= w_zcat[WIDTH+CHUNK-1:CHUNK];
               r_carry <= w_cout;
               r_k     <= r_k + KW'(1);
               if (w_last) begin
                  r_cout  <= w_cout;
                  r_ovf   <= w_cmsb ^ w_cout;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (OUT_READY) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign IN_READY  = (r_state == S_IDLE);
   assign OUT_VALID = (r_state == S_DONE);
   assign Z         = r_z;
   assign C_OUT     = r_cout;
   assign OVF       = r_ovf;
   assign ZERO      = (r_state == S_DONE) && (r_z == '0);

endmodule

`default_nettype wire
